// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream and writes it
// word by word into instruction memory, holding the core in reset until the load completes.
module imem_loader #(
   parameter int unsigned DEPTH = 512
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_in_valid,
   input  logic [7:0]  i_in_data,
   output logic        o_in_ready,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic        o_core_rst,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   state_t      r_state;
   logic [15:0] r_len;
   logic [15:0] r_word_idx;
   logic [1:0]  r_byte_idx;
   logic [23:0] r_word;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_core_rst;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_in_ready;
   logic        w_xfer;
   logic [15:0] w_new_len;
   logic        w_len_too_big;
   logic        w_last_word;

   assign w_in_ready    = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
   assign w_xfer        = i_in_valid && w_in_ready;
   assign w_new_len     = {i_in_data, r_len[7:0]};
   assign w_len_too_big = ({16'd0, w_new_len} > DEPTH);
   // word_idx < len always holds in WRITE, so the increment cannot wrap
   assign w_last_word   = ((r_word_idx + 16'd1) == r_len);

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= S_IDLE;
         r_len       <= 16'd0;
         r_word_idx  <= 16'd0;
         r_byte_idx  <= 2'd0;
         r_word      <= 24'd0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_core_rst  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_LEN0;
                  r_busy  <= 1'b1;
               end
            end
            S_LEN0: begin
               if (w_xfer) begin
                  r_len[7:0] <= i_in_data;
                  r_state    <= S_LEN1;
               end
            end
            S_LEN1: begin
               if (w_xfer) begin
                  r_len[15:8] <= i_in_data;
                  r_word_idx  <= 16'd0;
                  r_byte_idx  <= 2'd0;
                  if (w_new_len == 16'd0) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_core_rst <= 1'b1;
                     r_busy     <= 1'b0;
                  end else if (w_len_too_big) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_byte_idx <= r_byte_idx + 2'd1;
                  case (r_byte_idx)
                     2'd0: r_word[7:0]   <= i_in_data;
                     2'd1: r_word[15:8]  <= i_in_data;
                     2'd2: r_word[23:16] <= i_in_data;
                     default: begin
                        // fourth byte goes straight into the write data register
                        r_state     <= S_WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {14'd0, r_word_idx, 2'b00};
                        r_mem_wdata <= {i_in_data, r_word};
                     end
                  endcase
               end
            end
            S_WRITE: begin
               r_word_idx <= r_word_idx + 16'd1;
               r_byte_idx <= 2'd0;
               if (w_last_word) begin
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
                  r_core_rst <= 1'b1;
                  r_busy     <= 1'b0;
               end else begin
                  r_state <= S_DATA;
               end
            end
            S_DONE, S_ERR: begin
               if (i_start) begin
                  r_state    <= S_LEN0;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_core_rst <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_core_rst  = r_core_rst;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: fixed vector table, hand-written reset/restart sequences and
// randomized streams checked against a stream-level reference model.
module tb_imem_loader;
   localparam int DEPTH = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_in_valid  (in_valid),
      .i_in_data   (in_data),
      .o_in_ready  (in_ready),
      .o_mem_we    (mem_we),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_core_rst  (core_rst),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err)
   );

   typedef struct {
      int           nb;
      logic [95:0]  bytes;   // first stream byte in the top 8 bits
      int           gap;     // 0 = valid always, 1 = random, 2 = toggling
      bit           e_done;
      bit           e_err;
      int           e_nw;
      logic [31:0]  w0;
      logic [31:0]  w1;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  stream[$];
   logic [31:0] obs_addr[$];
   logic [31:0] obs_data[$];
   logic [31:0] exp_words[$];
   logic        obs_done, obs_err;
   bit          timed_out, bad_busy, bad_ready;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_addr"}, mem_addr, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_core_rst"}, core_rst, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   // Reference: a load is a 16-bit LE length then len LE words; zero is an empty
   // success, anything above DEPTH is rejected before any write.
   task automatic model(output bit e_done, output bit e_err);
      int len;
      exp_words.delete();
      len    = int'(stream[0]) + 256 * int'(stream[1]);
      e_done = (len <= DEPTH);
      e_err  = (len > DEPTH);
      if (e_done) begin
         for (int w = 0; w < len; w++) begin
            exp_words.push_back(32'(stream[2+4*w])
                              + 32'(stream[3+4*w]) * 32'h100
                              + 32'(stream[4+4*w]) * 32'h10000
                              + 32'(stream[5+4*w]) * 32'h1000000);
         end
      end
   endtask

   task automatic run_load(input int gap_mode, input bit hold_start);
      int idx;
      int budget;
      bit v;
      obs_addr.delete();
      obs_data.delete();
      timed_out = 0;
      bad_busy  = 0;
      bad_ready = 0;
      start = 1'b1;
      step();
      if (!hold_start) start = 1'b0;
      check("start_busy", busy, 1);
      check("start_core_rst", core_rst, 0);
      check("start_done", done, 0);
      check("start_err", err, 0);
      check("start_in_ready", in_ready, 1);
      idx    = 0;
      budget = stream.size() * 4 + 64;
      for (int cyc = 0; ; cyc++) begin
         if (mem_we) begin
            obs_addr.push_back(mem_addr);
            obs_data.push_back(mem_wdata);
            if (in_ready) bad_ready = 1;
         end
         if (done || err) break;
         if (!busy) bad_busy = 1;
         if (cyc >= budget) begin
            timed_out = 1;
            break;
         end
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = 1'($urandom_range(0, 1));
            default: v = cyc[0];
         endcase
         v = v && (idx < stream.size());
         in_valid = v;
         in_data  = v ? stream[idx] : 8'($urandom);
         if (v && in_ready) idx++;
         step();
      end
      in_valid = 1'b0;
      obs_done = done;
      obs_err  = err;
   endtask

   task automatic compare_results(input string tag, input bit e_done, input bit e_err);
      int n;
      check({tag, "_timeout"}, timed_out, 0);
      check({tag, "_nwrites"}, obs_addr.size(), exp_words.size());
      n = (obs_addr.size() < exp_words.size()) ? obs_addr.size() : exp_words.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_wr_addr"}, obs_addr[i], 32'(i * 4));
         check({tag, "_wr_data"}, obs_data[i], exp_words[i]);
      end
      check({tag, "_done"}, obs_done, e_done);
      check({tag, "_err"}, obs_err, e_err);
      check({tag, "_core_rst"}, core_rst, e_done);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_busy_during"}, bad_busy, 0);
      check({tag, "_ready_in_write"}, bad_ready, 0);
      $display("[TB] load %s: %0d stream bytes, %0d writes, done=%0b err=%0b",
               tag, stream.size(), obs_addr.size(), obs_done, obs_err);
   endtask

   task automatic random_stream(input int len);
      stream.delete();
      stream.push_back(8'(len));
      stream.push_back(8'(len >> 8));
      if (len <= DEPTH) begin
         for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
      end
   endtask

   vec_t vecs[6];
   bit   m_done, m_err;

   initial begin
      vecs[0] = '{10, 96'h020013051000B305A5000000, 0, 1, 0, 2, 32'h00100513, 32'h00A505B3};
      vecs[1] = '{2,  96'h000000000000000000000000, 0, 1, 0, 0, 32'h0, 32'h0};
      vecs[2] = '{2,  96'h010200000000000000000000, 0, 0, 1, 0, 32'h0, 32'h0};
      vecs[3] = '{6,  96'h0100EFBEADDE000000000000, 2, 1, 0, 1, 32'hDEADBEEF, 32'h0};
      vecs[4] = '{2,  96'hFFFF00000000000000000000, 1, 0, 1, 0, 32'h0, 32'h0};
      vecs[5] = '{10, 96'h0200112233448899AABB0000, 1, 1, 0, 2, 32'h44332211, 32'hBBAA9988};

      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      step();
      step();
      check_reset_outputs("por");
      rst = 1'b1;
      step();
      step();
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);

      for (int t = 0; t < 6; t++) begin
         stream.delete();
         for (int i = 0; i < vecs[t].nb; i++) stream.push_back(vecs[t].bytes[95-8*i -: 8]);
         exp_words.delete();
         if (vecs[t].e_nw > 0) exp_words.push_back(vecs[t].w0);
         if (vecs[t].e_nw > 1) exp_words.push_back(vecs[t].w1);
         run_load(vecs[t].gap, 1'b0);
         compare_results($sformatf("vec%0d", t), vecs[t].e_done, vecs[t].e_err);
      end

      // Reset two bytes into the first data word, then reload cleanly.
      stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h05, 8'hA5, 8'h00};
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = stream[k];
         step();
      end
      in_valid = 1'b0;
      check("midload_busy", busy, 1);
      rst = 1'b0;
      step();
      check_reset_outputs("midrst");
      rst = 1'b1;
      step();
      check("postrst_in_ready", in_ready, 0);
      $display("[TB] mid-load reset applied");
      model(m_done, m_err);
      run_load(0, 1'b0);
      compare_results("reload", m_done, m_err);

      // Start held high for the whole load: completes, then immediately restarts.
      stream = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      model(m_done, m_err);
      run_load(0, 1'b1);
      compare_results("hold_start", m_done, m_err);
      step();
      check("restart_busy", busy, 1);
      check("restart_done", done, 0);
      check("restart_core_rst", core_rst, 0);
      check("restart_in_ready", in_ready, 1);
      start = 1'b0;
      rst   = 1'b0;
      step();
      rst = 1'b1;
      step();

      // Length exactly DEPTH, then DEPTH+1.
      random_stream(DEPTH);
      model(m_done, m_err);
      run_load(0, 1'b0);
      compare_results("len_depth", m_done, m_err);
      random_stream(DEPTH + 1);
      model(m_done, m_err);
      run_load(0, 1'b0);
      compare_results("len_depth_p1", m_done, m_err);

      for (int r = 0; r < 24; r++) begin
         int sel;
         int len;
         sel = $urandom_range(0, 9);
         if (sel == 0)      len = 0;
         else if (sel <= 2) len = $urandom_range(DEPTH + 1, 65535);
         else               len = $urandom_range(1, 8);
         random_stream(len);
         model(m_done, m_err);
         run_load($urandom_range(0, 2), 1'b0);
         compare_results($sformatf("rand%0d", r), m_done, m_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
